// File: rtl/key_pkg.sv
// Shared types and helpers for the debounced-key event decoder.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } key_state_t;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the debounced key level and produces a one-cycle press strobe.
module key_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);

    logic r_key_q;
    logic r_armed;

    // r_armed stays low until the key has been seen released, so a key held
    // through reset cannot masquerade as a fresh press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key_q <= 1'b1;
            r_armed <= i_key;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            r_key_q <= i_key;
            if (i_key) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_press = r_armed & r_key_q & ~i_key;

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced active-low key level into short/long/repeat/double pulses.
module key_event_decoder #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DOUBLE_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic double_pulse,
    output logic key_held
);

    import key_pkg::*;

    localparam int unsigned LONG_CYC   = ms_to_cyc(CLK_HZ, LONG_MS);
    localparam int unsigned DOUBLE_CYC = ms_to_cyc(CLK_HZ, DOUBLE_MS);
    localparam int unsigned REPEAT_CYC = ms_to_cyc(CLK_HZ, REPEAT_MS);
    localparam int unsigned MAX_LD     = (LONG_CYC > DOUBLE_CYC) ? LONG_CYC : DOUBLE_CYC;
    localparam int unsigned MAX_CYC    = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC;
    localparam int          CNT_W      = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    if (LONG_CYC < 2 || DOUBLE_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
        $error("key_event_decoder: every derived cycle count must be at least 2");
    end

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_repeat_nxt;
    logic             w_double_nxt;
    logic             w_held_nxt;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             r_double;
    logic             r_held;

    key_edge_detect u_edge (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_key   (key_in),
        .o_press (w_press)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_press) begin
                    w_state_nxt = PRESS1;
                end
            end
            PRESS1: begin
                // Reaching the threshold wins over a release on the same edge.
                if (r_cnt == LONG_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = LONG;
                    w_cnt_nxt   = '0;
                end else if (key_in) begin
                    w_state_nxt = WAIT2;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT2: begin
                // A second press wins over window expiry on the same edge.
                if (!key_in) begin
                    w_double_nxt = 1'b1;
                    w_state_nxt  = PRESS2;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == DOUBLE_LAST) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESS2: begin
                w_cnt_nxt = '0;
                if (key_in) begin
                    w_state_nxt = IDLE;
                end
            end
            LONG: begin
                if (key_in) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_repeat_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_held_nxt = (w_state_nxt == PRESS1) || (w_state_nxt == PRESS2) || (w_state_nxt == LONG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_double <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_repeat <= w_repeat_nxt;
            r_double <= w_double_nxt;
            r_held   <= w_held_nxt;
        end
    end

    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign repeat_pulse = r_repeat;
    assign double_pulse = r_double;
    assign key_held     = r_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// Table-driven bench for key_event_decoder at 1 cycle per ms (LONG 20, DOUBLE 8, REPEAT 5).
module tb_key_event_decoder;

    // Output vector order: {short, long, repeat, double, held}
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] S = 5'b10000;
    localparam logic [4:0] L = 5'b01000;
    localparam logic [4:0] R = 5'b00100;
    localparam logic [4:0] D = 5'b00010;
    localparam logic [4:0] H = 5'b00001;

    typedef struct {
        string      tag;
        logic       rst;
        logic       key;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b1;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic double_pulse;
    logic key_held;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    key_event_decoder #(
        .CLK_HZ    (1000),
        .LONG_MS   (20),
        .DOUBLE_MS (8),
        .REPEAT_MS (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .double_pulse (double_pulse),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    task automatic add(input string tag, input logic r, input logic k, input logic [4:0] exp, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.tag = tag;
            v.rst = r;
            v.key = k;
            v.exp = exp;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {short_pulse, long_pulse, repeat_pulse, double_pulse, key_held};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {s,l,r,d,h}=%b expected %b", name, $time, got, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic k);
        @(negedge clk);
        rst    = r;
        key_in = k;
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input string name, input logic r, input logic k, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step(r, k);
            check(name, exp);
        end
    endtask

    initial begin
        add("reset",       1, 1, Z, 3);
        add("idle",        0, 1, Z, 2);

        add("short_hold",  0, 0, H, 5);
        add("short_rel",   0, 1, Z, 8);
        add("short_pulse", 0, 1, S, 1);
        add("short_after", 0, 1, Z, 3);

        add("long_hold",   0, 0, H, 20);
        add("long_pulse",  0, 0, L | H, 1);
        add("long_hold2",  0, 0, H, 4);
        add("repeat1",     0, 0, R | H, 1);
        add("long_hold3",  0, 0, H, 4);
        add("repeat2",     0, 0, R | H, 1);
        add("long_hold4",  0, 0, H, 4);
        add("repeat3",     0, 0, R | H, 1);
        add("long_hold5",  0, 0, H, 1);
        add("long_rel",    0, 1, Z, 10);

        add("dbl_p1",      0, 0, H, 3);
        add("dbl_gap",     0, 1, Z, 4);
        add("dbl_pulse",   0, 0, D | H, 1);
        add("dbl_p2",      0, 0, H, 2);
        add("dbl_rel",     0, 1, Z, 12);

        add("exp_p1",      0, 0, H, 3);
        add("exp_gap1",    0, 1, Z, 8);
        add("exp_short1",  0, 1, S, 1);
        add("exp_p2",      0, 0, H, 3);
        add("exp_gap2",    0, 1, Z, 8);
        add("exp_short2",  0, 1, S, 1);
        add("exp_idle",    0, 1, Z, 3);

        add("bnd_hold",    0, 0, H, 20);
        add("bnd_long",    0, 1, L | H, 1);
        add("bnd_exit",    0, 1, Z, 12);

        add("bnd_p1",      0, 0, H, 3);
        add("bnd_gap",     0, 1, Z, 8);
        add("bnd_dbl",     0, 0, D | H, 1);
        add("bnd_p2",      0, 0, H, 1);
        add("bnd_rel",     0, 1, Z, 12);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].key);
            check(vecs[i].tag, vecs[i].exp);
        end

        // Reset while waiting for a second press discards the pending short pulse.
        run_steps("rw_press",   0, 0, H, 3);
        run_steps("rw_wait",    0, 1, Z, 3);
        run_steps("rw_reset",   1, 1, Z, 2);
        run_steps("rw_quiet",   0, 1, Z, 14);

        // A key held low across reset deassertion is ignored until released.
        run_steps("hr_reset",   1, 0, Z, 3);
        run_steps("hr_held",    0, 0, Z, 25);
        run_steps("hr_release", 0, 1, Z, 2);
        run_steps("hr_press",   0, 0, H, 3);
        run_steps("hr_gap",     0, 1, Z, 8);
        run_steps("hr_short",   0, 1, S, 1);
        run_steps("hr_idle",    0, 1, Z, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
